// File: rtl/mem_req_ctrl_pkg.sv
// Shared definitions for the MEM-stage data SRAM request controller:
// FSM state encoding and access size codes.
package mem_req_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_DATA = 2'd1,
    ST_DATA_HELD = 2'd2,
    ST_DISCARD   = 2'd3
  } mem_state_t;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/mem_strb_gen.sv
// Byte-lane strobe and write-data replication for a single aligned access.
module mem_strb_gen
  import mem_req_ctrl_pkg::*;
(
  input  logic        we,
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_rep
);

  always_comb begin
    wstrb     = 4'b0000;
    wdata_rep = wdata;
    case (size)
      SIZE_B: begin
        wstrb     = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      SIZE_H: begin
        wstrb     = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
      end
      default: begin
        wstrb     = 4'b1111;
        wdata_rep = wdata;
      end
    endcase
    // Loads never write a lane, whatever their size.
    if (!we) wstrb = 4'b0000;
  end

endmodule

// File: rtl/mem_req_ctrl.sv
// Issues one data SRAM access at a time from EX and returns the response to
// MEM, holding the load word if WB stalls and discarding responses after flush.
module mem_req_ctrl
  import mem_req_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_req_valid,
  input  logic        ex_req_we,
  input  logic [1:0]  ex_req_size,
  input  logic [31:0] ex_req_addr,
  input  logic [31:0] ex_req_wdata,
  output logic        ex_req_ready,
  input  logic        flush,
  input  logic        ms_is_mem,
  input  logic        ms_leave,
  output logic        ms_ready_go,
  output logic [31:0] ms_rdata,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic [1:0]  state_dbg
);

  // Handshake: a request transfers on a cycle where data_sram_req and
  // data_sram_addr_ok are both high; EX keeps ex_req_* stable until then.
  mem_state_t  state, state_nxt;
  logic [31:0] hold_q;
  logic        capture;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset)        hold_q <= 32'd0;
    else if (capture) hold_q <= data_sram_rdata;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:
        if (ex_req_ready) state_nxt = ST_WAIT_DATA;
      ST_WAIT_DATA:
        if (flush)                  state_nxt = data_sram_data_ok ? ST_IDLE : ST_DISCARD;
        else if (data_sram_data_ok) state_nxt = ms_leave ? ST_IDLE : ST_DATA_HELD;
      ST_DATA_HELD:
        if (flush || ms_leave) state_nxt = ST_IDLE;
      ST_DISCARD:
        if (data_sram_data_ok) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    data_sram_req = ex_req_valid && (state == ST_IDLE) && !flush && !reset;
    ex_req_ready  = data_sram_req && data_sram_addr_ok;
    capture       = (state == ST_WAIT_DATA) && data_sram_data_ok && !flush && !ms_leave;
    ms_ready_go   = !ms_is_mem
                  || ((state == ST_WAIT_DATA) && data_sram_data_ok)
                  || (state == ST_DATA_HELD);
    ms_rdata      = (state == ST_DATA_HELD) ? hold_q : data_sram_rdata;
    state_dbg     = state;
  end

  assign data_sram_wr   = ex_req_we;
  assign data_sram_size = ex_req_size;
  assign data_sram_addr = ex_req_addr;

  mem_strb_gen u_strb (
    .we        (ex_req_we),
    .size      (ex_req_size),
    .addr_lo   (ex_req_addr[1:0]),
    .wdata     (ex_req_wdata),
    .wstrb     (data_sram_wstrb),
    .wdata_rep (data_sram_wdata)
  );

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl: cycle-by-cycle request/response scenarios
// with hand-computed expectations.
module tb_mem_req_ctrl;
  import mem_req_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_req_valid, ex_req_we;
  logic [1:0]  ex_req_size;
  logic [31:0] ex_req_addr, ex_req_wdata;
  logic        ex_req_ready;
  logic        flush, ms_is_mem, ms_leave, ms_ready_go;
  logic [31:0] ms_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [1:0]  state_dbg;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  mem_req_ctrl dut (
    .clk(clk), .reset(reset),
    .ex_req_valid(ex_req_valid), .ex_req_we(ex_req_we), .ex_req_size(ex_req_size),
    .ex_req_addr(ex_req_addr), .ex_req_wdata(ex_req_wdata), .ex_req_ready(ex_req_ready),
    .flush(flush), .ms_is_mem(ms_is_mem), .ms_leave(ms_leave),
    .ms_ready_go(ms_ready_go), .ms_rdata(ms_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata), .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Driver: present a request, optionally accepted this cycle.
  task automatic drive_req(input logic we, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic aok);
    ex_req_valid      = 1'b1;
    ex_req_we         = we;
    ex_req_size       = size;
    ex_req_addr       = addr;
    ex_req_wdata      = wdata;
    data_sram_addr_ok = aok;
    #1;
  endtask

  task automatic idle_inputs();
    ex_req_valid = 1'b0; data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
    flush = 1'b0; ms_leave = 1'b0; ms_is_mem = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    ex_req_we = 1'b0; ex_req_size = SIZE_W; ex_req_addr = 32'd0; ex_req_wdata = 32'd0;
    data_sram_rdata = 32'd0;
    idle_inputs();
    tick();
    // Reset cycle: request must be suppressed even with valid and addr_ok.
    drive_req(1'b0, SIZE_W, 32'h0000_1000, 32'd0, 1'b1);
    chk("rst_req", {31'd0, data_sram_req}, 32'd0);
    chk("rst_ready", {31'd0, ex_req_ready}, 32'd0);
    chk("rst_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
    tick();
    reset = 1'b0;
    idle_inputs();
    #1;

    // Word load, addr_ok cycle 0, data_ok + ms_leave cycle 2
    drive_req(1'b0, SIZE_W, 32'h0000_1000, 32'd0, 1'b1);
    chk("ld_req", {31'd0, data_sram_req}, 32'd1);
    chk("ld_ready", {31'd0, ex_req_ready}, 32'd1);
    chk("ld_wstrb", {28'd0, data_sram_wstrb}, 32'h0);
    chk("ld_addr", data_sram_addr, 32'h0000_1000);
    chk("ld_wr", {31'd0, data_sram_wr}, 32'd0);
    tick();
    idle_inputs(); ms_is_mem = 1'b1; #1;
    chk("ld_c1_state", {30'd0, state_dbg}, {30'd0, ST_WAIT_DATA});
    chk("ld_c1_rgo", {31'd0, ms_ready_go}, 32'd0);
    tick();
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF; ms_leave = 1'b1;
    exp_q.push_back(32'hDEAD_BEEF);
    #1;
    chk("ld_c2_rgo", {31'd0, ms_ready_go}, 32'd1);
    chk("ld_c2_rdata", ms_rdata, exp_q.pop_front());
    tick();
    idle_inputs(); #1;
    chk("ld_c3_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});

    // Store strobes and replicated data
    drive_req(1'b1, SIZE_B, 32'h0000_1003, 32'h0000_005A, 1'b0);
    chk("sb3_wstrb", {28'd0, data_sram_wstrb}, 32'h8);
    chk("sb3_wdata", data_sram_wdata, 32'h5A5A_5A5A);
    chk("sb3_wr", {31'd0, data_sram_wr}, 32'd1);
    chk("sb3_size", {30'd0, data_sram_size}, {30'd0, SIZE_B});
    drive_req(1'b1, SIZE_B, 32'h0000_1001, 32'h0000_00C3, 1'b0);
    chk("sb1_wstrb", {28'd0, data_sram_wstrb}, 32'h2);
    drive_req(1'b1, SIZE_H, 32'h0000_1000, 32'h0000_BEEF, 1'b0);
    chk("sh0_wstrb", {28'd0, data_sram_wstrb}, 32'h3);
    drive_req(1'b1, SIZE_W, 32'h0000_1004, 32'h1234_5678, 1'b0);
    chk("sw_wstrb", {28'd0, data_sram_wstrb}, 32'hF);
    chk("sw_wdata", data_sram_wdata, 32'h1234_5678);
    drive_req(1'b1, SIZE_H, 32'h0000_1002, 32'h0000_1234, 1'b1);
    chk("sh2_wstrb", {28'd0, data_sram_wstrb}, 32'hC);
    chk("sh2_wdata", data_sram_wdata, 32'h1234_1234);
    chk("sh2_ready", {31'd0, ex_req_ready}, 32'd1);
    tick();
    // Store waits for its write response before MEM hands off
    idle_inputs(); ms_is_mem = 1'b1; #1;
    chk("st_wait_rgo", {31'd0, ms_ready_go}, 32'd0);
    tick();
    data_sram_data_ok = 1'b1; ms_leave = 1'b1; #1;
    chk("st_resp_rgo", {31'd0, ms_ready_go}, 32'd1);
    tick();
    idle_inputs(); #1;
    chk("st_idle", {30'd0, state_dbg}, {30'd0, ST_IDLE});

    // Load with WB stalling: word held until ms_leave
    drive_req(1'b0, SIZE_W, 32'h0000_2000, 32'd0, 1'b1);
    tick();
    idle_inputs(); ms_is_mem = 1'b1; #1;
    tick();
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hCAFE_F00D;
    exp_q.push_back(32'hCAFE_F00D);
    #1;
    chk("hold_c2_rgo", {31'd0, ms_ready_go}, 32'd1);
    tick();
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'h1111_1111; ex_req_valid = 1'b1; #1;
    chk("hold_c3_state", {30'd0, state_dbg}, {30'd0, ST_DATA_HELD});
    chk("hold_c3_rdata", ms_rdata, 32'hCAFE_F00D);
    chk("hold_c3_rgo", {31'd0, ms_ready_go}, 32'd1);
    chk("hold_c3_req", {31'd0, data_sram_req}, 32'd0);
    tick();
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h2222_2222; #1;
    chk("hold_c4_rdata", ms_rdata, 32'hCAFE_F00D);
    tick();
    data_sram_data_ok = 1'b0; ms_leave = 1'b1; #1;
    chk("hold_c5_state", {30'd0, state_dbg}, {30'd0, ST_DATA_HELD});
    chk("hold_c5_rdata", ms_rdata, exp_q.pop_front());
    tick();
    idle_inputs(); #1;
    chk("hold_exit", {30'd0, state_dbg}, {30'd0, ST_IDLE});

    // Flush in WAIT_DATA, response arrives later and is dropped
    drive_req(1'b0, SIZE_W, 32'h0000_3000, 32'd0, 1'b1);
    tick();
    idle_inputs(); ex_req_valid = 1'b1; data_sram_addr_ok = 1'b1; flush = 1'b1; #1;
    chk("dis_c1_req", {31'd0, data_sram_req}, 32'd0);
    tick();
    flush = 1'b1; #1;
    chk("dis_c2_state", {30'd0, state_dbg}, {30'd0, ST_DISCARD});
    chk("dis_c2_req", {31'd0, data_sram_req}, 32'd0);
    tick();
    flush = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h3333_3333; #1;
    chk("dis_c3_state", {30'd0, state_dbg}, {30'd0, ST_DISCARD});
    chk("dis_c3_req", {31'd0, data_sram_req}, 32'd0);
    chk("dis_c3_ready", {31'd0, ex_req_ready}, 32'd0);
    tick();
    data_sram_data_ok = 1'b0; data_sram_addr_ok = 1'b0; #1;
    chk("dis_c4_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
    chk("dis_c4_req", {31'd0, data_sram_req}, 32'd1);
    idle_inputs(); #1;

    // Flush in IDLE blocks the request
    drive_req(1'b0, SIZE_W, 32'h0000_4000, 32'd0, 1'b1);
    flush = 1'b1; #1;
    chk("fl_idle_req", {31'd0, data_sram_req}, 32'd0);
    chk("fl_idle_ready", {31'd0, ex_req_ready}, 32'd0);
    tick();
    flush = 1'b0; #1;
    chk("fl_idle_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
    // Accepted now; flush coincides with data_ok
    tick();
    idle_inputs(); flush = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h4444_4444; #1;
    tick();
    idle_inputs(); #1;
    chk("fl_dok_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
    // Flush while DATA_HELD
    drive_req(1'b0, SIZE_W, 32'h0000_5000, 32'd0, 1'b1);
    tick();
    idle_inputs(); ms_is_mem = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h5555_5555; #1;
    tick();
    idle_inputs(); flush = 1'b1; #1;
    chk("fl_held_pre", {30'd0, state_dbg}, {30'd0, ST_DATA_HELD});
    tick();
    idle_inputs(); #1;
    chk("fl_held_post", {30'd0, state_dbg}, {30'd0, ST_IDLE});

    // addr_ok withheld for 4 cycles: request stays up with stable fields
    for (int i = 0; i < 4; i++) begin
      drive_req(1'b1, SIZE_W, 32'h0000_6000, 32'hA5A5_0F0F, 1'b0);
      chk($sformatf("aok_req%0d", i), {31'd0, data_sram_req}, 32'd1);
      chk($sformatf("aok_rdy%0d", i), {31'd0, ex_req_ready}, 32'd0);
      chk($sformatf("aok_addr%0d", i), data_sram_addr, 32'h0000_6000);
      tick();
    end
    drive_req(1'b1, SIZE_W, 32'h0000_6000, 32'hA5A5_0F0F, 1'b1);
    chk("aok_rdy_go", {31'd0, ex_req_ready}, 32'd1);
    chk("aok_wdata", data_sram_wdata, 32'hA5A5_0F0F);
    tick();
    idle_inputs(); #1;
    chk("aok_wait", {30'd0, state_dbg}, {30'd0, ST_WAIT_DATA});

    // Reset mid-access: back to IDLE with no DISCARD phase
    reset = 1'b1; ex_req_valid = 1'b1; data_sram_addr_ok = 1'b1; #1;
    chk("rst_mid_req", {31'd0, data_sram_req}, 32'd0);
    tick();
    reset = 1'b0; idle_inputs(); #1;
    chk("rst_mid_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog: the directed sequence is short; exceeding this is a bench hang.
  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
